preg_free_list: RTL and testbench

//  Circular free list of physical registers for the 3-wide rename stage; supplies up to 3 free

---
 rtl/preg_free_list.sv | 128 ++++++++++++
 tb/tb_preg_free_list.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags feeding the 3-wide rename stage.
// Build macro FREELIST_CHECK_EN adds a sticky overflow/underflow flag on err and saturates free_cnt.
module preg_free_list #(
   parameter int PREG_NUM = 64,
   parameter int AREG_NUM = 32,
   parameter int PREG_SEL = 6,
   parameter int FL_SEL   = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req_num,
   output logic                alloc_ok,
   output logic [PREG_SEL-1:0] alloc_preg1,
   output logic [PREG_SEL-1:0] alloc_preg2,
   output logic [PREG_SEL-1:0] alloc_preg3,
   input  logic [1:0]          commit_num,
   input  logic                rel_en1,
   input  logic                rel_en2,
   input  logic                rel_en3,
   input  logic [PREG_SEL-1:0] rel_preg1,
   input  logic [PREG_SEL-1:0] rel_preg2,
   input  logic [PREG_SEL-1:0] rel_preg3,
   input  logic                flush,
   output logic [FL_SEL:0]     free_cnt,
   output logic                err
);

   localparam int FL_DEPTH = PREG_NUM - AREG_NUM;

   typedef logic [PREG_SEL-1:0] tag_t;
   typedef logic [FL_SEL-1:0]   ptr_t;
   typedef logic [FL_SEL:0]     cnt_t;

   localparam cnt_t FL_FULL = cnt_t'(FL_DEPTH);

   tag_t mem [FL_DEPTH];
   ptr_t head;
   ptr_t chead;
   ptr_t tail;
   cnt_t spec_cnt;

   cnt_t req_ext;
   cnt_t commit_ext;
   cnt_t alloc_num;
   cnt_t rel_num;
   ptr_t wr_ptr2;
   ptr_t wr_ptr3;
   ptr_t head_nxt;
   ptr_t chead_nxt;
   cnt_t free_nxt;
   cnt_t spec_nxt;

   assign req_ext    = cnt_t'(req_num);
   assign commit_ext = cnt_t'(commit_num);
   assign alloc_ok   = !flush && (free_cnt >= req_ext);
   assign alloc_num  = alloc_ok ? req_ext : '0;
   assign rel_num    = cnt_t'(rel_en1) + cnt_t'(rel_en2) + cnt_t'(rel_en3);

   // Zero-cycle peek: tags are visible before the edge that consumes them.
   assign alloc_preg1 = mem[head];
   assign alloc_preg2 = mem[head + ptr_t'(1)];
   assign alloc_preg3 = mem[head + ptr_t'(2)];

   // Enabled releases are packed contiguously from tail in port order.
   assign wr_ptr2 = tail + ptr_t'(rel_en1);
   assign wr_ptr3 = wr_ptr2 + ptr_t'(rel_en2);

   assign chead_nxt = chead + ptr_t'(commit_num);
   assign head_nxt  = flush ? chead_nxt : head + ptr_t'(alloc_num);
   assign spec_nxt  = flush ? '0 : spec_cnt + alloc_num - commit_ext;

`ifdef FREELIST_CHECK_EN
   logic [FL_SEL+1:0] free_sum;
   logic              ovf;
   logic              unf;
   logic              err_q;

   always_comb begin
      free_sum = '0;
      if (flush) begin
         free_sum = {1'b0, free_cnt} + {1'b0, spec_cnt} - {1'b0, commit_ext} + {1'b0, rel_num};
      end else begin
         free_sum = {1'b0, free_cnt} - {1'b0, alloc_num} + {1'b0, rel_num};
      end
   end

   assign ovf      = free_sum > {1'b0, FL_FULL};
   assign unf      = commit_ext > spec_cnt;
   assign free_nxt = ovf ? FL_FULL : free_sum[FL_SEL:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (ovf || unf) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign free_nxt = flush ? (free_cnt + spec_cnt - commit_ext + rel_num)
                           : (free_cnt - alloc_num + rel_num);
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            mem[i] <= tag_t'(AREG_NUM + i);
         end
         head     <= '0;
         chead    <= '0;
         tail     <= '0;
         free_cnt <= FL_FULL;
         spec_cnt <= '0;
      end else begin
         if (rel_en1) mem[tail]    <= rel_preg1;
         if (rel_en2) mem[wr_ptr2] <= rel_preg2;
         if (rel_en3) mem[wr_ptr3] <= rel_preg3;
         head     <= head_nxt;
         chead    <= chead_nxt;
         tail     <= tail + ptr_t'(rel_num);
         free_cnt <= free_nxt;
         spec_cnt <= spec_nxt;
      end
   end

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: stimulus queues expected outputs, a negedge monitor compares.
module tb_preg_free_list;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] req_num;
   logic       alloc_ok;
   logic [5:0] alloc_preg1, alloc_preg2, alloc_preg3;
   logic [1:0] commit_num;
   logic       rel_en1, rel_en2, rel_en3;
   logic [5:0] rel_preg1, rel_preg2, rel_preg3;
   logic       flush;
   logic [5:0] free_cnt;
   logic       err;

   preg_free_list dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_num     (req_num),
      .alloc_ok    (alloc_ok),
      .alloc_preg1 (alloc_preg1),
      .alloc_preg2 (alloc_preg2),
      .alloc_preg3 (alloc_preg3),
      .commit_num  (commit_num),
      .rel_en1     (rel_en1),
      .rel_en2     (rel_en2),
      .rel_en3     (rel_en3),
      .rel_preg1   (rel_preg1),
      .rel_preg2   (rel_preg2),
      .rel_preg3   (rel_preg3),
      .flush       (flush),
      .free_cnt    (free_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tid;
      bit c_ok;
      bit ok;
      int ntag;
      int t1;
      int t2;
      int t3;
      int fc;
      bit c_err;
      bit er;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(input string nm, input int tid, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s (test %0d): got %0d, expected %0d", nm, tid, act, req);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.c_ok)     check("alloc_ok", mon_e.tid, int'(alloc_ok), int'(mon_e.ok));
         if (mon_e.ntag >= 1) check("alloc_preg1", mon_e.tid, int'(alloc_preg1), mon_e.t1);
         if (mon_e.ntag >= 2) check("alloc_preg2", mon_e.tid, int'(alloc_preg2), mon_e.t2);
         if (mon_e.ntag >= 3) check("alloc_preg3", mon_e.tid, int'(alloc_preg3), mon_e.t3);
         if (mon_e.fc >= 0)   check("free_cnt", mon_e.tid, int'(free_cnt), mon_e.fc);
         if (mon_e.c_err)     check("err", mon_e.tid, int'(err), int'(mon_e.er));
      end
   end

   task automatic push_exp(input int tid, input bit c_ok, input bit ok, input int ntag,
                           input int t1, input int t2, input int t3, input int fc,
                           input bit c_err, input bit er);
      exp_t e;
      e.tid = tid; e.c_ok = c_ok; e.ok = ok; e.ntag = ntag;
      e.t1 = t1; e.t2 = t2; e.t3 = t3; e.fc = fc; e.c_err = c_err; e.er = er;
      exp_q.push_back(e);
   endtask

   task automatic clear_in();
      req_num = 2'd0; commit_num = 2'd0; flush = 1'b0;
      rel_en1 = 1'b0; rel_en2 = 1'b0; rel_en3 = 1'b0;
      rel_preg1 = 6'd0; rel_preg2 = 6'd0; rel_preg3 = 6'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int fl[$];
      int pend[$];
      int mfc;
      int a1, a2, a3;
      int nrel;

      clear_in();
      #12 reset_n = 1'b1;
      tick();

      // Reset state and first allocations
      push_exp(0, 1, 1, 0, 0, 0, 0, 32, 1, 0);
      tick();
      req_num = 2'd3;
      push_exp(1, 1, 1, 3, 32, 33, 34, 32, 1, 0);
      tick();
      push_exp(1, 1, 1, 3, 35, 36, 37, 29, 0, 0);
      tick();

      // Drain to two free, refused request holds head
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req_num = 2'd3;
         push_exp(2, 1, 1, 3, 32 + 3*i, 33 + 3*i, 34 + 3*i, 32 - 3*i, 0, 0);
         tick();
      end
      req_num = 2'd3;
      push_exp(2, 1, 0, 0, 0, 0, 0, 2, 0, 0);
      tick();
      req_num = 2'd2;
      push_exp(2, 1, 1, 2, 62, 63, 0, 2, 0, 0);
      tick();

      // Empty list: compacted release, no same-cycle bypass
      clear_in();
      req_num = 2'd1;
      rel_en1 = 1'b1; rel_preg1 = 6'd5;
      rel_en3 = 1'b1; rel_preg3 = 6'd9;
      push_exp(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      clear_in();
      req_num = 2'd2;
      push_exp(3, 1, 1, 2, 5, 9, 0, 2, 0, 0);
      tick();
      clear_in();
      push_exp(3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Flush with same-cycle commit rewinds to committed head
      do_reset();
      req_num = 2'd3;
      push_exp(4, 1, 1, 3, 32, 33, 34, 32, 0, 0);
      tick();
      push_exp(4, 1, 1, 3, 35, 36, 37, 29, 0, 0);
      tick();
      flush = 1'b1; commit_num = 2'd2;
      push_exp(4, 1, 0, 0, 0, 0, 0, 26, 0, 0);
      tick();
      clear_in();
      req_num = 2'd1;
      push_exp(4, 1, 1, 1, 34, 0, 0, 30, 0, 0);
      tick();

      // Wrap-around: reference FIFO of free tags, releases shuffled across ports
      do_reset();
      fl.delete();
      pend.delete();
      for (int i = 0; i < 32; i++) fl.push_back(32 + i);
      mfc = 32;
      for (int c = 0; c < 40; c++) begin
         clear_in();
         req_num = 2'd3;
         push_exp(5, 1, 1, 3, fl[0], fl[1], fl[2], mfc, 0, 0);
         a1 = fl.pop_front(); a2 = fl.pop_front(); a3 = fl.pop_front();
         nrel = 0;
         if (pend.size() >= 3) begin
            rel_en1 = 1'b1; rel_preg1 = 6'(pend[2]);
            rel_en2 = 1'b1; rel_preg2 = 6'(pend[1]);
            rel_en3 = 1'b1; rel_preg3 = 6'(pend[0]);
            fl.push_back(pend[2]); fl.push_back(pend[1]); fl.push_back(pend[0]);
            void'(pend.pop_front()); void'(pend.pop_front()); void'(pend.pop_front());
            nrel = 3;
         end
         pend.push_back(a1); pend.push_back(a2); pend.push_back(a3);
         mfc = mfc - 3 + nrel;
         tick();
      end
      clear_in();
      push_exp(5, 1, 1, 3, fl[0], fl[1], fl[2], mfc, 0, 0);
      tick();

      // Release into a full list
      do_reset();
      rel_en1 = 1'b1; rel_preg1 = 6'd7;
      push_exp(6, 1, 1, 0, 0, 0, 0, 32, 1, 0);
      tick();
      clear_in();
`ifdef FREELIST_CHECK_EN
      push_exp(6, 0, 0, 0, 0, 0, 0, 32, 1, 1);
      tick();
      push_exp(6, 0, 0, 0, 0, 0, 0, 32, 1, 1);
      tick();
`else
      push_exp(6, 0, 0, 0, 0, 0, 0, -1, 1, 0);
      tick();
`endif
      do_reset();
      push_exp(6, 1, 1, 3, 32, 33, 34, 32, 1, 0);
      tick();

      // Async reset during an in-flight flush/commit
      do_reset();
      req_num = 2'd3;
      tick();
      clear_in();
      flush = 1'b1; commit_num = 2'd1;
      reset_n = 1'b0;
      push_exp(7, 1, 0, 3, 32, 33, 34, 32, 1, 0);
      tick();
      clear_in();
      reset_n = 1'b1;
      req_num = 2'd3;
      push_exp(7, 1, 1, 3, 32, 33, 34, 32, 1, 0);
      tick();
      clear_in();

      for (int w = 0; w < 5 && exp_q.size() > 0; w++) tick();
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expected items left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
